// File: rtl/data_mem_responder.sv
// data_mem_responder: fixed-latency word-addressed data memory for a pipeline MEM stage
// Ports: clk, reset (async, active-high); read_En/write_En/DataAddress/WriteData request;
// ReadData (held load result), rd_valid (load-done pulse), mem_stall (comb freeze), addr_err (reject pulse)
module data_mem_responder #(
  parameter int DEPTH   = 64,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        read_En,
  input  logic        write_En,
  input  logic [31:0] DataAddress,
  input  logic [31:0] WriteData,
  output logic [31:0] ReadData,
  output logic        rd_valid,
  output logic        mem_stall,
  output logic        addr_err
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2;
  logic [1:0]    state;
  logic [3:0]    cnt;
  logic          op_wr;
  logic [AW-1:0] idx;
  logic [31:0]   wdata;
  logic [31:0]   mem [DEPTH];
  logic          req, err, acc, last;
  always_comb begin
    req       = read_En | write_En;
    err       = req & ((read_En & write_En) | (|DataAddress[1:0]) | (DataAddress >= 32'(DEPTH * 4)));
    acc       = (state == IDLE) & req & ~err;
    last      = (state == BUSY) & (cnt == 4'd0);
    mem_stall = acc | (state == BUSY);
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state    <= IDLE;
      cnt      <= 4'd0;
      op_wr    <= 1'b0;
      idx      <= '0;
      wdata    <= '0;
      ReadData <= '0;
      rd_valid <= 1'b0;
      addr_err <= 1'b0;
    end else begin
      rd_valid <= last & ~op_wr;
      addr_err <= (state == IDLE) & err;
      if (acc) begin
        state <= BUSY;
        cnt   <= 4'(LATENCY - 1);
        op_wr <= write_En;
        idx   <= DataAddress[AW+1:2];
        wdata <= WriteData;
      end else if (last) state <= DONE;
      else if (state == BUSY) cnt <= cnt - 4'd1;
      else if (state == DONE) state <= IDLE;
      if (last & ~op_wr) ReadData <= mem[idx];
    end
  // storage is deliberately outside the reset domain; an abandoned store never reaches `last`
  always_ff @(posedge clk)
    if (last & op_wr) mem[idx] <= wdata;
endmodule

// File: tb/tb_data_mem_responder.sv
// tb_data_mem_responder: random + directed scoreboard bench for data_mem_responder
module tb_data_mem_responder;
  localparam int L = 2;
  logic clk = 0, reset = 1;
  logic read_En = 0, write_En = 0;
  logic [31:0] DataAddress = 0, WriteData = 0, ReadData;
  logic rd_valid, mem_stall, addr_err;
  logic b_rd = 0, b_wr = 0;
  logic [31:0] b_addr = 0, b_wd = 0, rdata1, rdata15;
  logic rv1, rv15, st1, st15, ae1, ae15;
  int cyc = 0, n_chk = 0, n_fail = 0;
  typedef struct {bit is_err; logic [31:0] data; int cyc;} exp_t;
  exp_t q[$];
  exp_t mx;
  logic [31:0] model [64];
  logic [31:0] exp_rdata = 0;

  data_mem_responder #(.DEPTH(64), .LATENCY(L)) dut (
    .clk(clk), .reset(reset), .read_En(read_En), .write_En(write_En),
    .DataAddress(DataAddress), .WriteData(WriteData), .ReadData(ReadData),
    .rd_valid(rd_valid), .mem_stall(mem_stall), .addr_err(addr_err));
  data_mem_responder #(.DEPTH(64), .LATENCY(1)) dut1 (
    .clk(clk), .reset(reset), .read_En(b_rd), .write_En(b_wr),
    .DataAddress(b_addr), .WriteData(b_wd), .ReadData(rdata1),
    .rd_valid(rv1), .mem_stall(st1), .addr_err(ae1));
  data_mem_responder #(.DEPTH(64), .LATENCY(15)) dut15 (
    .clk(clk), .reset(reset), .read_En(b_rd), .write_En(b_wr),
    .DataAddress(b_addr), .WriteData(b_wd), .ReadData(rdata15),
    .rd_valid(rv15), .mem_stall(st15), .addr_err(ae15));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: every rd_valid/addr_err pulse must match the oldest expected event
  always @(negedge clk) begin
    if (reset) begin
      q.delete();
      exp_rdata = 0;
    end else begin
      if (rd_valid || addr_err) begin
        if (q.size() == 0) check("unexpected_pulse", {30'd0, rd_valid, addr_err}, 32'd0);
        else begin
          mx = q.pop_front();
          check("pulse_cycle", cyc, mx.cyc);
          check("addr_err", {31'd0, addr_err}, {31'd0, mx.is_err});
          check("rd_valid", {31'd0, rd_valid}, {31'd0, !mx.is_err});
          if (!mx.is_err) exp_rdata = mx.data;
        end
      end else if (q.size() != 0 && q[0].cyc < cyc) begin
        check("missing_pulse_cycle", cyc, q[0].cyc);
        void'(q.pop_front());
      end
      check("ReadData", ReadData, exp_rdata);
    end
  end

  task automatic idle();
    read_En = 0; write_En = 0; DataAddress = 0; WriteData = 0;
  endtask

  // Issue one request, hold it for its whole stall window, and record the expected outcome
  task automatic access(input logic rd, input logic wr, input logic [31:0] a, input logic [31:0] d);
    bit e;
    int c0;
    exp_t x;
    @(negedge clk);
    read_En = rd; write_En = wr; DataAddress = a; WriteData = d;
    c0 = cyc;
    e = (rd && wr) || a[1:0] != 0 || a >= 256;
    #1;
    check("stall_c0", {31'd0, mem_stall}, {31'd0, !e});
    if (e) begin
      x.is_err = 1; x.data = 0; x.cyc = c0 + 1;
      q.push_back(x);
      @(negedge clk);
      idle();
    end else begin
      if (rd) begin
        x.is_err = 0; x.data = model[a[7:2]]; x.cyc = c0 + L + 1;
        q.push_back(x);
      end else model[a[7:2]] = d;
      for (int i = 1; i <= L; i++) begin
        @(negedge clk);
        check("stall_busy", {31'd0, mem_stall}, 32'd1);
      end
      @(negedge clk);
      check("stall_done", {31'd0, mem_stall}, 32'd0);
      idle();
    end
  endtask

  initial begin
    int c0, f1, f15;
    logic [31:0] d1, d15, a;
    logic rd, wr;
    repeat (2) @(negedge clk);
    check("rst_ReadData", ReadData, 0);
    check("rst_rd_valid", {31'd0, rd_valid}, 0);
    check("rst_addr_err", {31'd0, addr_err}, 0);
    check("rst_stall", {31'd0, mem_stall}, 0);
    reset = 0;
    for (int w = 0; w < 64; w++) access(0, 1, w * 4, $urandom);
    access(0, 1, 32'h10, 32'hDEADBEEF);
    access(1, 0, 32'h10, 0);
    access(0, 1, 32'h0, 32'h11111111);
    access(0, 1, 32'h4, 32'h22222222);
    access(1, 0, 32'h0, 0);
    access(1, 0, 32'h4, 0);
    access(1, 0, 32'h13, 0);
    access(1, 0, 32'h100, 0);
    access(1, 1, 32'h8, 32'h55);
    access(1, 0, 32'h8, 0);
    for (int n = 0; n < 300; n++) begin
      int r;
      r = $urandom_range(0, 9);
      rd = (r < 4) || (r == 8);
      wr = (r >= 4);
      r = $urandom_range(0, 9);
      a = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
      if (r == 8) a[1:0] = 2'($urandom_range(1, 3));
      if (r == 9) a = 32'd256 + $urandom_range(0, 1000);
      access(rd, wr, a, $urandom);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    // abandon a store by resetting in its first busy cycle
    @(negedge clk);
    write_En = 1; DataAddress = 32'h20; WriteData = 32'hCAFEF00D;
    #1 check("st_stall", {31'd0, mem_stall}, 1);
    @(negedge clk);
    #3 reset = 1;
    #1;
    check("rst_mid_ReadData", ReadData, 0);
    check("rst_mid_rd_valid", {31'd0, rd_valid}, 0);
    check("rst_mid_addr_err", {31'd0, addr_err}, 0);
    check("rst_mid_stall", {31'd0, mem_stall}, 1);
    @(negedge clk);
    idle();
    @(negedge clk);
    reset = 0;
    access(1, 0, 32'h20, 0);
    // latency extremes
    @(negedge clk);
    b_wr = 1; b_addr = 32'hFC; b_wd = 32'h5A5AA5A5;
    @(negedge clk);
    b_wr = 0;
    repeat (20) @(negedge clk);
    b_rd = 1;
    c0 = cyc; f1 = -1; f15 = -1; d1 = 0; d15 = 0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      b_rd = 0;
      if (rv1 && f1 < 0) begin f1 = cyc; d1 = rdata1; end
      if (rv15 && f15 < 0) begin f15 = cyc; d15 = rdata15; end
    end
    check("lat1_cycle", f1, c0 + 2);
    check("lat15_cycle", f15, c0 + 16);
    check("lat1_data", d1, 32'h5A5AA5A5);
    check("lat15_data", d15, 32'h5A5AA5A5);
    repeat (3) @(negedge clk);
    check("queue_drained", q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
